// File: rtl/route_executor_pkg.sv
// Shared types and helpers for the route executor: FSM states, throat turnout
// indices and the route-to-turnout / route-to-signal maps.
package route_executor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_PULSE,
      ST_WAIT_DET,
      ST_LOCKED,
      ST_FAULT
   } state_t;

   localparam logic [1:0] TURNOUT_LEFT_FIRST  = 2'd0;
   localparam logic [1:0] TURNOUT_RIGHT_FIRST = 2'd2;

   // Station bit 1 sets the outer turnout of the throat, bit 0 the inner one.
   function automatic logic [3:0] route_targets(input logic side, input logic [1:0] station);
      return side ? {station[0], station[1], 2'b00} : {2'b00, station[0], station[1]};
   endfunction

   function automatic logic [3:0] route_mask(input logic side);
      return side ? 4'b1100 : 4'b0011;
   endfunction

   function automatic logic [3:0] signal_onehot(input logic side, input logic approach);
      return 4'b0001 << {side, approach};
   endfunction

endpackage

// File: rtl/route_executor_cycle_timer.sv
// Loadable down-counter shared by the motor pulse and the detection timeout;
// holds at zero rather than wrapping.
module route_executor_cycle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/route_executor.sv
// Sets one interlocked route: moves and proves each throat turnout in turn,
// then locks the route and clears the approach signal until release or fault.
module route_executor
   import route_executor_pkg::*;
#(
   parameter int NUM_TURNOUTS   = 4,
   parameter int PULSE_CYCLES   = 25_000_000,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_side,
   input  logic                    req_approach,
   input  logic [1:0]              req_station,
   // "release" is a reserved word in SystemVerilog, hence the longer name.
   input  logic                    route_release,
   input  logic                    fault_ack,
   input  logic [NUM_TURNOUTS-1:0] det_pos,
   input  logic [NUM_TURNOUTS-1:0] det_valid,
   output logic [NUM_TURNOUTS-1:0] motor_en,
   output logic [NUM_TURNOUTS-1:0] motor_dir,
   output logic [3:0]              signal_green,
   output logic                    route_locked,
   output logic                    fault,
   output logic [1:0]              fault_turnout
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [1:0]              r_idx;
   logic [1:0]              w_idx_next;
   logic                    r_side;
   logic                    r_approach;
   logic [1:0]              r_station;
   logic [NUM_TURNOUTS-1:0] r_motor_dir;
   logic [1:0]              r_fault_turnout;

   logic [NUM_TURNOUTS-1:0] w_targets;
   logic [NUM_TURNOUTS-1:0] w_mask;
   logic [NUM_TURNOUTS-1:0] w_ok;
   logic [NUM_TURNOUTS-1:0] w_lost;
   logic                    w_cur_ok;
   logic                    w_capture;
   logic                    w_dir_load;
   logic                    w_fault_set;
   logic                    w_fault_clear;
   logic [1:0]              w_fault_idx;
   logic                    w_timer_load;
   logic [CW-1:0]           w_timer_value;
   logic                    w_timer_done;

   assign w_targets = route_targets(r_side, r_station);
   assign w_mask    = route_mask(r_side);
   assign w_ok      = det_valid & ~(det_pos ^ w_targets);
   assign w_lost    = w_mask & ~w_ok;
   assign w_cur_ok  = w_ok[r_idx];

   route_executor_cycle_timer #(
      .WIDTH(CW)
   ) u_timer (
      .i_clk        (CLOCK_50),
      .i_rst_n      (RESET_N),
      .i_load       (w_timer_load),
      .i_load_value (w_timer_value),
      .o_done       (w_timer_done)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state         <= ST_IDLE;
         r_idx           <= '0;
         r_side          <= 1'b0;
         r_approach      <= 1'b0;
         r_station       <= '0;
         r_motor_dir     <= '0;
         r_fault_turnout <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) begin
            r_side     <= req_side;
            r_approach <= req_approach;
            r_station  <= req_station;
            r_idx      <= req_side ? TURNOUT_RIGHT_FIRST : TURNOUT_LEFT_FIRST;
         end else begin
            r_idx <= w_idx_next;
         end
         if (w_dir_load) begin
            r_motor_dir[r_idx] <= w_targets[r_idx];
         end
         if (w_fault_set) begin
            r_fault_turnout <= w_fault_idx;
         end else if (w_fault_clear) begin
            r_fault_turnout <= '0;
         end
      end
   end

   // After a successful move, WAIT_DET returns to CHECK on the same turnout,
   // which re-proves it and advances in one cycle.
   always_comb begin
      w_next_state  = r_state;
      w_idx_next    = r_idx;
      w_capture     = 1'b0;
      w_dir_load    = 1'b0;
      w_fault_set   = 1'b0;
      w_fault_clear = 1'b0;
      w_fault_idx   = r_idx;
      w_timer_load  = 1'b0;
      w_timer_value = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_capture    = 1'b1;
               w_next_state = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_cur_ok) begin
               if (r_idx[0]) begin
                  w_next_state = ST_LOCKED;
               end else begin
                  w_idx_next = r_idx + 2'd1;
               end
            end else begin
               w_next_state  = ST_PULSE;
               w_dir_load    = 1'b1;
               w_timer_load  = 1'b1;
               w_timer_value = CW'(PULSE_CYCLES - 1);
            end
         end
         ST_PULSE: begin
            if (w_timer_done) begin
               w_next_state  = ST_WAIT_DET;
               w_timer_load  = 1'b1;
               w_timer_value = CW'(TIMEOUT_CYCLES - 1);
            end
         end
         ST_WAIT_DET: begin
            if (w_cur_ok) begin
               w_next_state = ST_CHECK;
            end else if (w_timer_done) begin
               w_next_state = ST_FAULT;
               w_fault_set  = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_lost != '0) begin
               w_next_state = ST_FAULT;
               w_fault_set  = 1'b1;
               w_fault_idx  = w_lost[{r_side, 1'b0}] ? {r_side, 1'b0} : {r_side, 1'b1};
            end else if (route_release) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (fault_ack) begin
               w_next_state  = ST_IDLE;
               w_fault_clear = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready     = (r_state == ST_IDLE);
      motor_en      = (r_state == ST_PULSE) ? (NUM_TURNOUTS'(1) << r_idx) : '0;
      motor_dir     = r_motor_dir;
      signal_green  = (r_state == ST_LOCKED) ? signal_onehot(r_side, r_approach) : 4'b0000;
      route_locked  = (r_state == ST_LOCKED);
      fault         = (r_state == ST_FAULT);
      fault_turnout = r_fault_turnout;
   end

endmodule

// File: tb/tb_route_executor.sv
// Scoreboard bench for route_executor with a simple turnout model that moves
// detection to the commanded direction when a motor pulse ends.
module tb_route_executor;

   localparam int PULSE   = 4;
   localparam int TIMEOUT = 10;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic       reqValid = 1'b0;
   logic       reqReady;
   logic       reqSide = 1'b0;
   logic       reqApproach = 1'b0;
   logic [1:0] reqStation = 2'd0;
   logic       routeRelease = 1'b0;
   logic       faultAck = 1'b0;
   logic [3:0] detPos = 4'b0000;
   logic [3:0] detValid = 4'b0000;
   logic [3:0] motorEn;
   logic [3:0] motorDir;
   logic [3:0] signalGreen;
   logic       routeLocked;
   logic       faultOut;
   logic [1:0] faultTurnout;

   typedef struct {
      logic [3:0] green;
      logic       fault;
      logic [1:0] faultTurnout;
   } expectation_t;

   expectation_t sb[$];
   int         checkCount = 0;
   int         errorCount = 0;
   int         cycleNum = 0;
   logic [3:0] prevEn = 4'b0000;
   logic [3:0] seenEn = 4'b0000;
   logic [3:0] follow = 4'b1111;
   int         pulseCount[4];
   int         firstEn[4];

   route_executor #(
      .NUM_TURNOUTS   (4),
      .PULSE_CYCLES   (PULSE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .CLOCK_50      (clock),
      .RESET_N       (resetN),
      .req_valid     (reqValid),
      .req_ready     (reqReady),
      .req_side      (reqSide),
      .req_approach  (reqApproach),
      .req_station   (reqStation),
      .route_release (routeRelease),
      .fault_ack     (faultAck),
      .det_pos       (detPos),
      .det_valid     (detValid),
      .motor_en      (motorEn),
      .motor_dir     (motorDir),
      .signal_green  (signalGreen),
      .route_locked  (routeLocked),
      .fault         (faultOut),
      .fault_turnout (faultTurnout)
   );

   always #5 clock = ~clock;

   // Hard stop in case something upstream never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock, sampled 1 time unit after the edge, then the turnout model reacts.
   task automatic tick();
      @(posedge clock);
      #1;
      cycleNum++;
      for (int i = 0; i < 4; i++) begin
         if (motorEn[i]) begin
            pulseCount[i]++;
            seenEn[i] = 1'b1;
            if (!prevEn[i]) firstEn[i] = cycleNum;
         end
         if (prevEn[i] && !motorEn[i] && follow[i]) begin
            detPos[i]   = motorDir[i];
            detValid[i] = 1'b1;
         end
      end
      prevEn = motorEn;
   endtask

   task automatic applyStimulus(input logic side, input logic approach, input logic [1:0] station,
                                input logic [3:0] expGreen, input logic expFault, input logic [1:0] expTurnout);
      expectation_t e;
      reqValid    = 1'b1;
      reqSide     = side;
      reqApproach = approach;
      reqStation  = station;
      e.green        = expGreen;
      e.fault        = expFault;
      e.faultTurnout = expTurnout;
      sb.push_back(e);
   endtask

   task automatic waitOutcome(input string tag, output int cycles);
      expectation_t e;
      cycles = 0;
      while (!(routeLocked || faultOut) && cycles < 60) begin
         tick();
         cycles++;
      end
      checkOutput({tag, " timeout"}, (routeLocked || faultOut) ? 0 : 1, 0);
      if (routeLocked || faultOut) begin
         checkOutput({tag, " sbAvail"}, (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, " green"}, signalGreen, e.green);
            checkOutput({tag, " fault"}, faultOut, e.fault);
            checkOutput({tag, " locked"}, routeLocked, !e.fault);
            checkOutput({tag, " faultTurnout"}, faultTurnout, e.faultTurnout);
         end
      end
   endtask

   task automatic waitPulse(input string tag);
      int n = 0;
      while (motorEn == 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      checkOutput({tag, " pulseSeen"}, (motorEn != 4'b0000) ? 1 : 0, 1);
   endtask

   task automatic releaseRoute(input string tag);
      routeRelease = 1'b1;
      tick();
      routeRelease = 1'b0;
      checkOutput({tag, " relLocked"}, routeLocked, 0);
      checkOutput({tag, " relGreen"}, signalGreen, 4'b0000);
      checkOutput({tag, " relReady"}, reqReady, 1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4; i++) begin
         pulseCount[i] = 0;
         firstEn[i]    = 0;
      end

      // Reset with left-throat detection already matching left/S3.
      detPos   = 4'b0001;
      detValid = 4'b1111;
      tick();
      tick();
      checkOutput("rst motorEn", motorEn, 4'b0000);
      checkOutput("rst motorDir", motorDir, 4'b0000);
      checkOutput("rst green", signalGreen, 4'b0000);
      checkOutput("rst locked", routeLocked, 0);
      checkOutput("rst fault", faultOut, 0);
      checkOutput("rst faultTurnout", faultTurnout, 0);
      resetN = 1'b1;
      tick();
      checkOutput("rst ready", reqReady, 1);

      // Left/L2/S3 with everything already set: best-case latency, no motor.
      seenEn = 4'b0000;
      applyStimulus(1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 2'd0);
      tick();
      reqValid = 1'b0;
      checkOutput("t1 readyLow", reqReady, 0);
      waitOutcome("t1", n);
      checkOutput("t1 latency", n + 1, 3);
      checkOutput("t1 motorNever", seenEn, 4'b0000);
      releaseRoute("t1");

      // Left/L1/S4 from T0=T1=normal: both turnouts pulsed reverse in order.
      detPos[1:0] = 2'b00;
      seenEn = 4'b0000;
      for (int i = 0; i < 4; i++) pulseCount[i] = 0;
      applyStimulus(1'b0, 1'b0, 2'd3, 4'b0001, 1'b0, 2'd0);
      tick();
      reqValid = 1'b0;
      waitOutcome("t2", n);
      checkOutput("t2 pulseT0", pulseCount[0], PULSE);
      checkOutput("t2 pulseT1", pulseCount[1], PULSE);
      checkOutput("t2 order", (firstEn[0] < firstEn[1]) ? 1 : 0, 1);
      checkOutput("t2 dirLeft", motorDir[1:0], 2'b11);
      checkOutput("t2 rightUntouched", seenEn[3:2], 2'b00);
      releaseRoute("t2");

      // Right/R4/S2 with T2 stuck reverse: timeout fault on T2.
      detPos[2] = 1'b1;
      follow[2] = 1'b0;
      applyStimulus(1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd2);
      tick();
      reqValid = 1'b0;
      waitOutcome("t3", n);
      checkOutput("t3 faultDelay", cycleNum - firstEn[2], PULSE + TIMEOUT);
      checkOutput("t3 motorOff", motorEn, 4'b0000);
      faultAck    = 1'b1;
      reqValid    = 1'b1;
      reqSide     = 1'b0;
      reqApproach = 1'b0;
      reqStation  = 2'd0;
      tick();
      faultAck = 1'b0;
      checkOutput("t3 ackReady", reqReady, 1);
      checkOutput("t3 ackFault", faultOut, 0);
      checkOutput("t3 ackTurnout", faultTurnout, 0);
      reqValid = 1'b0;

      // Right/R3/S1 locked, then detection loss together with release.
      follow[2] = 1'b1;
      applyStimulus(1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd0);
      tick();
      reqValid = 1'b0;
      waitOutcome("t4", n);
      detValid[3]  = 1'b0;
      routeRelease = 1'b1;
      tick();
      routeRelease = 1'b0;
      checkOutput("t4 lossFault", faultOut, 1);
      checkOutput("t4 lossGreen", signalGreen, 4'b0000);
      checkOutput("t4 lossLocked", routeLocked, 0);
      tick();
      checkOutput("t4 faultHolds", faultOut, 1);
      faultAck = 1'b1;
      tick();
      faultAck    = 1'b0;
      detValid[3] = 1'b1;
      checkOutput("t4 ackFault", faultOut, 0);

      // Left/L1/S1, with a second request held from mid-pulse until IDLE.
      applyStimulus(1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0);
      tick();
      reqValid = 1'b0;
      waitPulse("t5");
      applyStimulus(1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 2'd0);
      tick();
      checkOutput("t5 readyInPulse", reqReady, 0);
      waitOutcome("t5a", n);
      checkOutput("t5 readyLocked", reqReady, 0);
      releaseRoute("t5");
      tick();
      reqValid = 1'b0;
      checkOutput("t5 accepted", reqReady, 0);
      waitOutcome("t5b", n);
      checkOutput("t5 dirRight", motorDir[3:2], 2'b11);
      releaseRoute("t5b");

      // Reset asserted in the middle of a motor pulse.
      reqValid    = 1'b1;
      reqSide     = 1'b0;
      reqApproach = 1'b1;
      reqStation  = 2'd2;
      tick();
      reqValid = 1'b0;
      waitPulse("t6");
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("t6 motorEn", motorEn, 4'b0000);
      checkOutput("t6 motorDir", motorDir, 4'b0000);
      checkOutput("t6 green", signalGreen, 4'b0000);
      checkOutput("t6 locked", routeLocked, 0);
      checkOutput("t6 fault", faultOut, 0);
      checkOutput("t6 ready", reqReady, 1);
      #3;
      resetN = 1'b1;
      tick();
      checkOutput("t6 motorAfter", motorEn, 4'b0000);
      checkOutput("sb empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
